// File: rtl/aes_ptxt_unpacker.sv
// Block FIFO that buffers 128-bit AES plaintext blocks and
// streams them one 32-bit word at a time to the nibble aligner.
module aes_ptxt_unpacker #(
  parameter int DEPTH     = 2,
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] blk_data,
  input  logic [2:0]   blk_nwords,
  input  logic         blk_last,
  input  logic         blk_vld,
  output logic         blk_rdy,
  input  logic         flush,
  output logic [31:0]  aes_ptxt,
  output logic         aes_ptxt_vld,
  input  logic         aes_ptxt_rdy,
  output logic         aes_ptxt_last,
  output logic [3:0]   fill_level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [127:0] data;
    logic [1:0]   nw;
    logic         last;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    widx_q, widx_d;
  logic [31:0]   word_q, word_d;

  logic   full, empty, push, pop, hs, head_done;
  entry_t head, new_e, nxt_head;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [31:0] word_sel(
    input logic [127:0] d,
    input logic [1:0]   k
  );
    logic [1:0] s;
    s = MSW_FIRST ? 2'd3 - k : k;
    unique case (s)
      2'd0:    return d[31:0];
      2'd1:    return d[63:32];
      2'd2:    return d[95:64];
      default: return d[127:96];
    endcase
  endfunction

  assign full      = cnt_q == 4'(DEPTH);
  assign empty     = cnt_q == 4'd0;
  assign blk_rdy   = reset_n & ~full & ~flush;
  assign push      = blk_vld & blk_rdy;
  assign head      = mem_q[rptr_q];
  assign head_done = widx_q == head.nw;
  assign hs        = ~empty & aes_ptxt_rdy;
  assign pop       = hs & head_done;

  // nw holds (word count - 1); 0 and out-of-range counts mean 4
  always_comb begin
    new_e.data = blk_data;
    new_e.last = blk_last;
    unique case (blk_nwords)
      3'd1:    new_e.nw = 2'd0;
      3'd2:    new_e.nw = 2'd1;
      3'd3:    new_e.nw = 2'd2;
      default: new_e.nw = 2'd3;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    widx_d = widx_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      widx_d = '0;
    end else begin
      if (push) wptr_d = inc(wptr_q);
      if (pop)  rptr_d = inc(rptr_q);
      if (hs)   widx_d = head_done ? 2'd0 : widx_q + 2'd1;
      if (push && !pop)      cnt_d = cnt_q + 4'd1;
      else if (pop && !push) cnt_d = cnt_q - 4'd1;
    end
  end

  // Output word is registered from next-state head so it holds when empty
  always_comb begin
    if (push && (wptr_q == rptr_d)) nxt_head = new_e;
    else                            nxt_head = mem_q[rptr_d];
    if (cnt_d != 4'd0) word_d = word_sel(nxt_head.data, widx_d);
    else               word_d = word_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      widx_q <= '0;
      word_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      widx_q <= widx_d;
      word_q <= word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= new_e;
  end

  assign aes_ptxt      = word_q;
  assign aes_ptxt_vld  = ~empty;
  assign aes_ptxt_last = ~empty & head.last & head_done;
  assign fill_level    = cnt_q;

endmodule

// File: tb/tb_aes_ptxt_unpacker.sv
// Directed bench for aes_ptxt_unpacker: ordering, back-pressure,
// full/partial/flush/reset behaviour and LSW-first variant.
module tb_aes_ptxt_unpacker;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [127:0] blk_data = '0;
  logic [2:0]   blk_nwords = 3'd4;
  logic         blk_last = 1'b0;
  logic         blk_vld = 1'b0;
  logic         blk_rdy;
  logic         flush = 1'b0;
  logic [31:0]  aes_ptxt;
  logic         aes_ptxt_vld;
  logic         aes_ptxt_rdy = 1'b0;
  logic         aes_ptxt_last;
  logic [3:0]   fill_level;

  logic [127:0] b2_data = '0;
  logic         b2_vld = 1'b0;
  logic         b2_rdy;
  logic [31:0]  p2;
  logic         p2_vld;
  logic         p2_rdy = 1'b0;
  logic         p2_last;
  logic [3:0]   fill2;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] BLK = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  always #5 clk = ~clk;

  aes_ptxt_unpacker #(.DEPTH(2), .MSW_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .blk_data(blk_data), .blk_nwords(blk_nwords),
    .blk_last(blk_last), .blk_vld(blk_vld), .blk_rdy(blk_rdy),
    .flush(flush), .aes_ptxt(aes_ptxt), .aes_ptxt_vld(aes_ptxt_vld),
    .aes_ptxt_rdy(aes_ptxt_rdy), .aes_ptxt_last(aes_ptxt_last),
    .fill_level(fill_level)
  );

  aes_ptxt_unpacker #(.DEPTH(2), .MSW_FIRST(1'b0)) dut_lsw (
    .clk(clk), .reset_n(reset_n),
    .blk_data(b2_data), .blk_nwords(3'd4),
    .blk_last(1'b0), .blk_vld(b2_vld), .blk_rdy(b2_rdy),
    .flush(1'b0), .aes_ptxt(p2), .aes_ptxt_vld(p2_vld),
    .aes_ptxt_rdy(p2_rdy), .aes_ptxt_last(p2_last),
    .fill_level(fill2)
  );

  task automatic push(input logic [127:0] d, input logic [2:0] nw,
                      input logic l);
    @(negedge clk);
    blk_data = d; blk_nwords = nw; blk_last = l; blk_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    blk_vld = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (blk_rdy !== 1'b0 || aes_ptxt_vld !== 1'b0 || aes_ptxt !== 32'h0 ||
        aes_ptxt_last !== 1'b0 || fill_level !== 4'd0) begin
      errors++;
      $display("FAIL reset_vals rdy=%b vld=%b ptxt=%h last=%b fill=%0d need 0",
               blk_rdy, aes_ptxt_vld, aes_ptxt, aes_ptxt_last, fill_level);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (blk_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy got %b need 1", blk_rdy);
    end
  endtask

  task automatic test_single;
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h00112233; exp_w[1] = 32'h44556677;
    exp_w[2] = 32'h8899AABB; exp_w[3] = 32'hCCDDEEFF;
    aes_ptxt_rdy = 1'b1;
    push(BLK, 3'd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (aes_ptxt_vld !== 1'b1 || aes_ptxt !== exp_w[k] ||
          aes_ptxt_last !== 1'b0) begin
        errors++;
        $display("FAIL single_w%0d got vld=%b %h last=%b need 1 %h 0",
                 k, aes_ptxt_vld, aes_ptxt, aes_ptxt_last, exp_w[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (aes_ptxt_vld !== 1'b0 || aes_ptxt !== 32'hCCDDEEFF ||
        fill_level !== 4'd0) begin
      errors++;
      $display("FAIL single_end got vld=%b %h fill=%0d need 0 ccddeeff 0",
               aes_ptxt_vld, aes_ptxt, fill_level);
    end
  endtask

  task automatic test_backpressure;
    aes_ptxt_rdy = 1'b1;
    push(BLK, 3'd4, 1'b0);
    @(negedge clk);
    aes_ptxt_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (aes_ptxt_vld !== 1'b1 || aes_ptxt !== 32'h44556677) begin
        errors++;
        $display("FAIL bp_hold%0d got vld=%b %h need 1 44556677",
                 i, aes_ptxt_vld, aes_ptxt);
      end
    end
    aes_ptxt_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (aes_ptxt !== 32'h8899AABB) begin
      errors++;
      $display("FAIL bp_w2 got %h need 8899aabb", aes_ptxt);
    end
    @(negedge clk);
    checks++;
    if (aes_ptxt !== 32'hCCDDEEFF || aes_ptxt_vld !== 1'b1) begin
      errors++;
      $display("FAIL bp_w3 got vld=%b %h need 1 ccddeeff",
               aes_ptxt_vld, aes_ptxt);
    end
    @(negedge clk);
    checks++;
    if (aes_ptxt_vld !== 1'b0) begin
      errors++;
      $display("FAIL bp_end vld got %b need 0", aes_ptxt_vld);
    end
  endtask

  task automatic test_full;
    int n;
    aes_ptxt_rdy = 1'b0;
    push({4{32'h11111111}}, 3'd4, 1'b0);
    push({4{32'h22222222}}, 3'd4, 1'b0);
    checks++;
    if (blk_rdy !== 1'b0 || fill_level !== 4'd2) begin
      errors++;
      $display("FAIL full_state got rdy=%b fill=%0d need 0 2",
               blk_rdy, fill_level);
    end
    blk_data = {4{32'h33333333}}; blk_nwords = 3'd4; blk_vld = 1'b1;
    aes_ptxt_rdy = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (blk_rdy) break;
    end
    checks++;
    if (n !== 4 || aes_ptxt !== 32'h22222222) begin
      errors++;
      $display("FAIL full_reopen got cycles=%0d ptxt=%h need 4 22222222",
               n, aes_ptxt);
    end
    @(posedge clk);
    @(negedge clk);
    blk_vld = 1'b0;
    checks++;
    if (fill_level !== 4'd2) begin
      errors++;
      $display("FAIL full_push3 fill got %0d need 2", fill_level);
    end
    for (int i = 0; i < 20; i++) begin
      if (!aes_ptxt_vld) break;
      @(negedge clk);
    end
    checks++;
    if (aes_ptxt_vld !== 1'b0 || fill_level !== 4'd0 ||
        aes_ptxt !== 32'h33333333) begin
      errors++;
      $display("FAIL full_drain got vld=%b fill=%0d %h need 0 0 33333333",
               aes_ptxt_vld, fill_level, aes_ptxt);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    aes_ptxt_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      blk_data = {32'hA0000000 + 32'(i), 96'h0};
      blk_nwords = 3'd1; blk_last = 1'b0; blk_vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (fill_level !== 4'd1 || aes_ptxt_vld !== 1'b1 ||
          aes_ptxt !== 32'hA0000000 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_%0d got fill=%0d vld=%b %h need 1 1 %h",
                 i, fill_level, aes_ptxt_vld, aes_ptxt,
                 32'hA0000000 + 32'(i));
      end
    end
    blk_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (aes_ptxt_vld !== 1'b0 || aes_ptxt !== 32'hA0000002 ||
        fill_level !== 4'd0) begin
      errors++;
      $display("FAIL b2b_hold got vld=%b %h fill=%0d need 0 a0000002 0",
               aes_ptxt_vld, aes_ptxt, fill_level);
    end
  endtask

  task automatic test_partial;
    aes_ptxt_rdy = 1'b1;
    push(BLK, 3'd2, 1'b1);
    checks++;
    if (aes_ptxt !== 32'h00112233 || aes_ptxt_last !== 1'b0) begin
      errors++;
      $display("FAIL part_w0 got %h last=%b need 00112233 0",
               aes_ptxt, aes_ptxt_last);
    end
    @(negedge clk);
    checks++;
    if (aes_ptxt !== 32'h44556677 || aes_ptxt_last !== 1'b1 ||
        aes_ptxt_vld !== 1'b1) begin
      errors++;
      $display("FAIL part_w1 got vld=%b %h last=%b need 1 44556677 1",
               aes_ptxt_vld, aes_ptxt, aes_ptxt_last);
    end
    @(negedge clk);
    checks++;
    if (aes_ptxt_vld !== 1'b0 || aes_ptxt_last !== 1'b0) begin
      errors++;
      $display("FAIL part_end got vld=%b last=%b need 0 0",
               aes_ptxt_vld, aes_ptxt_last);
    end
  endtask

  task automatic test_nwords0;
    int words;
    int last_at;
    aes_ptxt_rdy = 1'b1;
    push(BLK, 3'd0, 1'b1);
    words = 0;
    last_at = -1;
    for (int i = 0; i < 8; i++) begin
      if (!aes_ptxt_vld) break;
      if (aes_ptxt_last) last_at = words;
      words++;
      @(negedge clk);
    end
    checks++;
    if (words !== 4 || last_at !== 3 || aes_ptxt !== 32'hCCDDEEFF) begin
      errors++;
      $display("FAIL nw0 got words=%0d last_at=%0d %h need 4 3 ccddeeff",
               words, last_at, aes_ptxt);
    end
  endtask

  task automatic test_lsw_first;
    @(negedge clk);
    b2_data = BLK; b2_vld = 1'b1; p2_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b2_vld = 1'b0;
    checks++;
    if (p2 !== 32'hCCDDEEFF || p2_vld !== 1'b1 || fill2 !== 4'd1) begin
      errors++;
      $display("FAIL lsw_w0 got vld=%b %h fill=%0d need 1 ccddeeff 1",
               p2_vld, p2, fill2);
    end
    p2_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (p2 !== 32'h8899AABB) begin
      errors++;
      $display("FAIL lsw_w1 got %h need 8899aabb", p2);
    end
  endtask

  task automatic test_flush;
    aes_ptxt_rdy = 1'b0;
    push({4{32'h55555555}}, 3'd4, 1'b0);
    push({4{32'h66666666}}, 3'd4, 1'b0);
    @(negedge clk);
    aes_ptxt_rdy = 1'b1;
    flush = 1'b1;
    blk_data = {4{32'h77777777}}; blk_vld = 1'b1;
    #1;
    checks++;
    if (blk_rdy !== 1'b0 || fill_level !== 4'd2) begin
      errors++;
      $display("FAIL flush_cyc got rdy=%b fill=%0d need 0 2",
               blk_rdy, fill_level);
    end
    @(negedge clk);
    flush = 1'b0;
    blk_vld = 1'b0;
    #1;
    checks++;
    if (fill_level !== 4'd0 || aes_ptxt_vld !== 1'b0 || blk_rdy !== 1'b1) begin
      errors++;
      $display("FAIL flush_after got fill=%0d vld=%b rdy=%b need 0 0 1",
               fill_level, aes_ptxt_vld, blk_rdy);
    end
  endtask

  task automatic test_reset_mid;
    aes_ptxt_rdy = 1'b1;
    push(BLK, 3'd4, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (blk_rdy !== 1'b0 || aes_ptxt_vld !== 1'b0 || aes_ptxt !== 32'h0 ||
        aes_ptxt_last !== 1'b0 || fill_level !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b vld=%b %h last=%b fill=%0d need 0",
               blk_rdy, aes_ptxt_vld, aes_ptxt, aes_ptxt_last, fill_level);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (aes_ptxt_vld !== 1'b0 || blk_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got vld=%b rdy=%b need 0 1",
               aes_ptxt_vld, blk_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full();
    test_back_to_back();
    test_partial();
    test_nwords0();
    test_lsw_first();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
